mouse_tracker: RTL
==================

MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 SHALL have parameters: SCREEN_W, default 640, horizontal pixel count; SCREEN_H, default 480, vertical pixel count; TIMEOUT_CYCLES, default 100000, clk cycles of PS/2 inactivity that abort a frame or packet.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ps2_clk, input, 1, PS/2 device clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1, PS/2 device data, asynchronous to clk.
REQ-006 SHALL have port mouse_x, output, 10, cursor column, drives the graphics mouse_x input.
REQ-007 SHALL have port mouse_y, output, 10, cursor row, drives the graphics mouse_y input.
REQ-008 SHALL have ports btn_left and btn_right, output, 1 each, button state from the last accepted packet.
REQ-009 SHALL have port pkt_valid, output, 1, one-cycle pulse on each position update.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on each rejected byte or timeout abort.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; a PS/2 falling edge is synced previous value 1 and synced current value 0.
REQ-012 SHALL run a frame FSM IDLE->DATA->PARITY->STOP->IDLE, sampling synced ps2_data once per falling edge.
REQ-013 IDLE SHALL leave on a sampled 0 (start bit) and SHALL ignore a sampled 1.
REQ-014 DATA SHALL shift in 8 bits LSB first.
REQ-015 PARITY SHALL require odd parity over the 8 data bits plus the parity bit.
REQ-016 STOP SHALL require a sampled 1.
REQ-017 A parity or stop failure SHALL discard the byte, pulse frame_err, and return the packet assembler to byte 0.
REQ-018 The packet assembler SHALL collect byte0 (flags), byte1 (dx), byte2 (dy).
REQ-019 A byte0 with bit3 = 0 SHALL be dropped silently, so the assembler stays at byte 0 (resync).
REQ-020 Each delta SHALL be 9-bit two's complement: dx = {byte0[4], byte1}, dy = {byte0[5], byte2}.
REQ-021 byte0[6] set SHALL force dx = 0; byte0[7] set SHALL force dy = 0.
REQ-022 The new position SHALL be x = mouse_x + dx and y = mouse_y - dy (PS/2 +Y is up), computed in 12-bit signed arithmetic.
REQ-023 Without wrap, x SHALL clamp to [0, SCREEN_W-1] and y to [0, SCREEN_H-1].
REQ-024 mouse_x, mouse_y, btn_left (byte0[0]) and btn_right (byte0[1]) SHALL update, and pkt_valid SHALL be 1, exactly one clk after the falling edge that samples byte2's valid stop bit.
REQ-025 A timeout SHALL occur when the frame FSM is not IDLE, or the assembler is at byte 1 or 2, and TIMEOUT_CYCLES clk cycles pass with no falling edge.
REQ-026 A timeout SHALL return the FSM to IDLE and the assembler to byte 0, and SHALL pulse frame_err once.
REQ-027 Outputs SHALL hold between updates.
REQ-028 pkt_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-029 Reset SHALL set mouse_x = SCREEN_W/2 (320), mouse_y = SCREEN_H/2 (240), btn_left = btn_right = pkt_valid = frame_err = 0.
REQ-030 Reset SHALL set the frame FSM to IDLE, the assembler to byte 0, the timeout counter to 0, and both synchronizers to 1.
REQ-031 Reset asserted mid-frame or mid-packet SHALL discard all partial data; the first start bit after reset SHALL begin a fresh byte 0.

Configuration
REQ-032 With macro MOUSE_WRAP_EN defined, out-of-range positions SHALL wrap modulo SCREEN_W / SCREEN_H instead of clamping.
REQ-033 Under MOUSE_WRAP_EN, dx and dy SHALL be added as signed values modulo the screen size (e.g. x = 639 with dx = +1 gives 0; x = 0 with dx = -1 gives 639).
REQ-034 Without MOUSE_WRAP_EN, REQ-023 clamping SHALL apply and no wrap logic SHALL be synthesized.

Verification
REQ-035 Scenario: reset -> mouse_x = 320, mouse_y = 240, pkt_valid = 0, frame_err = 0.
REQ-036 Scenario: packet 0x09, 0x05, 0x03 after reset -> mouse_x = 325, mouse_y = 237, btn_left = 1, one pkt_valid pulse.
REQ-037 Scenario: packet 0x18, 0xF6, 0x00 after reset -> mouse_x = 310, mouse_y = 240.
REQ-038 Scenario: packet 0x08, 0x7F, 0x00 sent 3x from reset -> mouse_x = 447, then 574, then 639 (clamped); with MOUSE_WRAP_EN, the third gives 61.
REQ-039 Scenario: byte1 with bad parity, then valid packet 0x08, 0x01, 0x00 -> one frame_err pulse, no update on the bad packet, then mouse_x = 321.
REQ-040 Scenario: TIMEOUT_CYCLES = 50; byte0 0x08 sent, then 60 idle cycles, then packet 0x08, 0x02, 0x00 -> one frame_err pulse, then mouse_x = 322.

Source files
------------

// File: rtl/mouse_tracker.sv
// mouse_tracker: PS/2 mouse receiver turning 3-byte packets into a clamped (or, with MOUSE_WRAP_EN, wrapped) cursor position.
module mouse_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       pkt_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [11:0] W = 12'(SCREEN_W);
  localparam logic signed [11:0] H = 12'(SCREEN_H);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] c_sync, d_sync;
  logic c_prev, fall, d, par_ok, active, timeout, byte_ok, byte_bad;
  logic [2:0] bit_cnt;
  logic [7:0] sr, b1;
  logic [5:0] flags;
  logic [1:0] idx;
  logic [TW-1:0] tcnt;
  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0] cx, cy;
  assign d       = d_sync[1];
  assign fall    = c_prev & ~c_sync[1];
  assign active  = state != IDLE || idx != 2'd0;
  assign timeout = active && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n  = state;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = d ? IDLE : DATA;
        DATA:    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n  = IDLE;
          byte_ok  = d & par_ok;
          byte_bad = ~(d & par_ok);
        end
      endcase
  end
  // flags = {y_ovf, x_ovf, y_sign, x_sign, right, left}; byte2 is still in sr when it completes
  always_comb begin
    dx = flags[4] ? 12'sd0 : {{4{flags[2]}}, b1};
    dy = flags[5] ? 12'sd0 : {{4{flags[3]}}, sr};
    nx = $signed({2'b00, mouse_x}) + dx;
    ny = $signed({2'b00, mouse_y}) - dy;
`ifdef MOUSE_WRAP_EN
    cx = nx < 0 ? 10'(nx + W) : nx >= W ? 10'(nx - W) : nx[9:0];
    cy = ny < 0 ? 10'(ny + H) : ny >= H ? 10'(ny - H) : ny[9:0];
`else
    cx = nx < 0 ? 10'd0 : nx >= W ? 10'(W - 1) : nx[9:0];
    cy = ny < 0 ? 10'd0 : ny >= H ? 10'(H - 1) : ny[9:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      c_prev    <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      par_ok    <= 1'b0;
      idx       <= '0;
      flags     <= '0;
      b1        <= '0;
      tcnt      <= '0;
      mouse_x   <= 10'(SCREEN_W / 2);
      mouse_y   <= 10'(SCREEN_H / 2);
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2_clk};
      d_sync    <= {d_sync[0], ps2_data};
      c_prev    <= c_sync[1];
      state     <= state_n;
      pkt_valid <= 1'b0;
      frame_err <= byte_bad | timeout;
      tcnt      <= (fall || !active || timeout) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        sr      <= {d, sr[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state == PARITY) par_ok <= ^{sr, d};
      if (timeout || byte_bad) idx <= '0;
      else if (byte_ok)
        case (idx)
          2'd0: if (sr[3]) begin
            flags <= {sr[7:4], sr[1:0]};
            idx   <= 2'd1;
          end
          2'd1: begin
            b1  <= sr;
            idx <= 2'd2;
          end
          default: begin
            mouse_x   <= cx;
            mouse_y   <= cy;
            btn_left  <= flags[0];
            btn_right <= flags[1];
            pkt_valid <= 1'b1;
            idx       <= 2'd0;
          end
        endcase
    end
  end
endmodule
